// File: rtl/my_seq_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : my_adder_pkg
//  Description : Shared types and helpers for the sequential chunked adder:
//                FSM state encoding, default geometry constants and the
//                signed-overflow rule.
//  Revision    : 1.0 - initial release
// ============================================================================
package my_adder_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic sum_msb);
        return (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/my_seq_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : my_seq_adder_if
//  Description : Start/busy/done handshake and operand/result bundle for
//                my_seq_adder.
//                master : drives start, a, b, cin, sat; observes results
//                slave  : the adder itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface my_seq_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sat;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sat,
        input  busy, done, out, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sat,
        output busy, done, out, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/my_seq_adder_chunk.sv
`default_nettype none
// ============================================================================
//  Module      : my_chunk_adder
//  Description : Combinational CHUNK-bit adder with carry in and carry out.
//  Ports       : a_i, b_i   - CHUNK-bit addends
//                cin_i      - carry in
//                sum_o      - CHUNK-bit sum
//                cout_o     - carry out of the chunk MSB
//  Revision    : 1.0 - initial release
// ============================================================================
module my_chunk_adder #(
    parameter int CHUNK = 4
) (
    input  wire logic [CHUNK-1:0] a_i,
    input  wire logic [CHUNK-1:0] b_i,
    input  wire logic             cin_i,
    output logic      [CHUNK-1:0] sum_o,
    output logic                  cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};

endmodule
`default_nettype wire

// File: rtl/my_seq_adder.sv
`default_nettype none
// ============================================================================
//  Module      : my_seq_adder
//  Description : Multi-cycle unsigned adder. Adds two WIDTH-bit operands
//                CHUNK bits per clock through a single reused chunk adder,
//                carrying between chunks in a register. Reports raw carry-out
//                and signed overflow; optional unsigned saturation.
//  Ports       : clk  - system clock, rising edge
//                rst  - synchronous reset, active-high
//                bus  - my_seq_adder_if.slave (start/a/b/cin/sat in,
//                       busy/done/out/cout/ovf out)
//  Revision    : 1.0 - initial release
// ============================================================================
import my_adder_pkg::*;

module my_seq_adder #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  wire logic      clk,
    input  wire logic      rst,
    my_seq_adder_if.slave  bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q,     a_d;
    logic [WIDTH-1:0]   b_q,     b_d;
    logic               sat_q,   sat_d;
    logic [WIDTH-1:0]   sum_q,   sum_d;
    logic [WIDTH-1:0]   out_q,   out_d;
    logic               cout_q,  cout_d;
    logic               ovf_q,   ovf_d;

    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK-1:0]   w_csum;
    logic               w_ccout;

    // Select the operand chunk addressed by the counter; the one adder
    // instance is time-shared across all chunk cycles.
    assign w_a_chunk = a_q[int'(cnt_q)*CHUNK +: CHUNK];
    assign w_b_chunk = b_q[int'(cnt_q)*CHUNK +: CHUNK];

    my_chunk_adder #(
        .CHUNK  (CHUNK)
    ) u_chunk_adder (
        .a_i    (w_a_chunk),
        .b_i    (w_b_chunk),
        .cin_i  (carry_q),
        .sum_o  (w_csum),
        .cout_o (w_ccout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sat_d   = sat_q;
        sum_d   = sum_q;
        out_d   = out_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sat_d   = bus.sat;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[int'(cnt_q)*CHUNK +: CHUNK] = w_csum;
                carry_d = w_ccout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // sum_d now holds the complete raw sum; w_ccout is the
                    // carry out of the operand MSB.
                    cnt_d   = '0;
                    out_d   = (sat_q && w_ccout) ? {WIDTH{1'b1}} : sum_d;
                    cout_d  = w_ccout;
                    ovf_d   = signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], sum_d[WIDTH-1]);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sat_q   <= 1'b0;
            sum_q   <= '0;
            out_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sat_q   <= sat_d;
            sum_q   <= sum_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.out  = out_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_my_seq_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_my_seq_adder
//  Description : Self-checking bench for my_seq_adder. A 16/4 instance runs a
//                vector table plus handshake, start-while-busy and mid-run
//                reset sequences; a 16/16 instance covers single-chunk mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_my_seq_adder;

    localparam int W  = 16;
    localparam int NC = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    my_seq_adder_if #(.WIDTH(W)) bus ();
    my_seq_adder_if #(.WIDTH(W)) bus16 ();

    my_seq_adder #(.WIDTH(W), .CHUNK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    my_seq_adder #(.WIDTH(W), .CHUNK(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sat;
        logic [15:0] out;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Issue one operation on the 16/4 instance and wait (bounded) for done.
    // lat is the edge index (accepting edge = 0) after which done is seen.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic s,
                         output int lat, output int busy_n, output logic ok);
        bus.a = a; bus.b = b; bus.cin = ci; bus.sat = s; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a = ~a; bus.b = ~b; bus.cin = ~ci; bus.sat = ~s;
        lat = 0;
        busy_n = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) busy_n++;
            tick();
            lat++;
        end
        ok = bus.done;
    endtask

    initial begin
        int   lat;
        int   busy_n;
        int   dones;
        logic ok;
        logic [15:0] held;

        checks = 0;
        errors = 0;
        bus.start = 0; bus.a = 0; bus.b = 0; bus.cin = 0; bus.sat = 0;
        bus16.start = 0; bus16.a = 0; bus16.b = 0; bus16.cin = 0; bus16.sat = 0;

        vecs[0] = '{16'd1024,  16'd1,     1'b0, 1'b0, 16'd1025,  1'b0, 1'b0};
        vecs[1] = '{16'd65535, 16'd1,     1'b0, 1'b0, 16'd0,     1'b1, 1'b0};
        vecs[2] = '{16'd65535, 16'd1,     1'b0, 1'b1, 16'd65535, 1'b1, 1'b0};
        vecs[3] = '{16'd32767, 16'd1,     1'b0, 1'b0, 16'd32768, 1'b0, 1'b1};
        vecs[4] = '{16'd65534, 16'd0,     1'b1, 1'b0, 16'd65535, 1'b0, 1'b0};
        vecs[5] = '{16'h8000,  16'h8000,  1'b0, 1'b0, 16'h0000,  1'b1, 1'b1};
        vecs[6] = '{16'h8000,  16'h8000,  1'b0, 1'b1, 16'hFFFF,  1'b1, 1'b1};
        vecs[7] = '{16'h1234,  16'h4321,  1'b1, 1'b0, 16'h5556,  1'b0, 1'b0};
        vecs[8] = '{16'hFFFF,  16'hFFFF,  1'b1, 1'b0, 16'hFFFF,  1'b1, 1'b0};
        vecs[9] = '{16'h0FFF,  16'h0001,  1'b0, 1'b1, 16'h1000,  1'b0, 1'b0};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_out",  32'(bus.out),  32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf",  32'(bus.ovf),  32'd0);
        tick();

        // Vector table
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sat, lat, busy_n, ok);
            chk($sformatf("v%0d_done_seen", i), 32'(ok), 32'd1);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(NC));
            chk($sformatf("v%0d_busy_cycles", i), 32'(busy_n), 32'(NC));
            chk($sformatf("v%0d_out", i), 32'(bus.out), 32'(vecs[i].out));
            chk($sformatf("v%0d_cout", i), 32'(bus.cout), 32'(vecs[i].cout));
            chk($sformatf("v%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].ovf));
            tick();
            chk($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
            chk($sformatf("v%0d_idle_busy", i), 32'(bus.busy), 32'd0);
        end

        // Result held while idle
        held = bus.out;
        repeat (3) tick();
        chk("idle_hold_out", 32'(bus.out), 32'(held));

        // start during RUN ignored; start held into DONE accepted
        bus.a = 16'd1; bus.b = 16'd2; bus.cin = 1'b0; bus.sat = 1'b0; bus.start = 1'b1;
        tick();
        bus.a = 16'd1024; bus.b = 16'd1024;
        lat = 0;
        while (!bus.done && lat < 20) begin
            tick();
            lat++;
        end
        chk("busy_start_latency", 32'(lat), 32'(NC));
        chk("busy_start_out", 32'(bus.out), 32'd3);
        tick();
        bus.start = 1'b0;
        chk("done_start_busy", 32'(bus.busy), 32'd1);
        chk("done_start_done", 32'(bus.done), 32'd0);
        lat = 0;
        while (!bus.done && lat < 20) begin
            tick();
            lat++;
        end
        chk("b2b_latency", 32'(lat), 32'(NC));
        chk("b2b_out", 32'(bus.out), 32'd2048);
        tick();

        // Reset on the second RUN edge
        bus.a = 16'd5; bus.b = 16'd6; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_out",  32'(bus.out),  32'd0);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);
        do_op(16'd1024, 16'd1, 1'b0, 1'b0, lat, busy_n, ok);
        chk("post_rst_latency", 32'(lat), 32'(NC));
        chk("post_rst_out", 32'(bus.out), 32'd1025);
        tick();

        // Single-chunk instance
        bus16.a = 16'd1024; bus16.b = 16'd1; bus16.cin = 1'b0; bus16.sat = 1'b0;
        bus16.start = 1'b1;
        tick();
        bus16.start = 1'b0;
        chk("c16_busy", 32'(bus16.busy), 32'd1);
        chk("c16_no_early_done", 32'(bus16.done), 32'd0);
        tick();
        chk("c16_done", 32'(bus16.done), 32'd1);
        chk("c16_out", 32'(bus16.out), 32'd1025);
        chk("c16_cout", 32'(bus16.cout), 32'd0);
        tick();
        chk("c16_done_pulse", 32'(bus16.done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
